// File: rtl/instr_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// instr_fetch_ctrl
//
// Instruction fetch sequencer between the combinational instruction ROM and
// the decode stage. Owns the program counter, fetches one word per cycle into
// a small FIFO (word + PC), and hands the FIFO head to decode over a
// valid/ready handshake. Handles branch redirects, level-sensitive halt and
// misaligned redirect targets (sticky fault until reset).
//
// Ports:
//   clk            core clock, all state updates on the rising edge
//   rst            synchronous active-high reset
//   imem_addr      ROM byte address (the PC register)
//   imem_instr     ROM data for imem_addr, same cycle
//   if_valid       FIFO head valid towards decode
//   if_ready       decode accepts the head this cycle
//   if_pc          PC of the FIFO head
//   if_instr       instruction word of the FIFO head
//   redirect_valid taken branch/jump, load redirect_pc
//   redirect_pc    redirect target
//   halt_req       level, stop issuing new fetches while high
//   fetch_err      sticky misaligned-redirect fault flag
//   fetch_state    0=RUN, 1=HALT, 2=FAULT
//   fetch_count    number of instructions accepted by decode (wraps)
// -----------------------------------------------------------------------------
module instr_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt_req,
    output logic        fetch_err,
    output logic [1:0]  fetch_state,
    output logic [31:0] fetch_count
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_FAULT = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic          err_q, err_d;
    logic [31:0]   fcnt_q, fcnt_d;

    logic [31:0]   pc_mem_q    [DEPTH];
    logic [31:0]   instr_mem_q [DEPTH];

    logic          redir_live;
    logic          redir_bad;
    logic          push;
    logic          pop;

    // Redirects are dead once faulted; FAULT only leaves through reset.
    assign redir_live = redirect_valid && (state_q != ST_FAULT);
    assign redir_bad  = redir_live && (redirect_pc[1:0] != 2'b00);

    // The head is withheld during any redirect cycle so decode never
    // consumes a word that is about to be flushed.
    assign if_valid = (cnt_q != '0) && !redirect_valid && (state_q != ST_FAULT);
    assign pop      = if_valid && if_ready;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push = (state_q == ST_RUN) && !halt_req && !redirect_valid &&
                  ((cnt_q < DEPTH_C) || pop);

    assign imem_addr   = pc_q;
    assign if_pc       = pc_mem_q[rptr_q];
    assign if_instr    = instr_mem_q[rptr_q];
    assign fetch_err   = err_q;
    assign fetch_state = state_q;
    assign fetch_count = fcnt_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        err_d   = err_q;
        fcnt_d  = fcnt_q;

        if (redir_live) begin
            // Redirect outranks push, pop and halt: flush and retarget, or
            // fault without touching the PC when the target is misaligned.
            cnt_d  = '0;
            wptr_d = '0;
            rptr_d = '0;
            if (redir_bad) begin
                state_d = ST_FAULT;
                err_d   = 1'b1;
            end else begin
                pc_d = redirect_pc;
            end
        end else begin
            if (push) begin
                wptr_d = wptr_q + 1'b1;
                pc_d   = pc_q + 32'd4;
            end
            if (pop) begin
                rptr_d = rptr_q + 1'b1;
                fcnt_d = fcnt_q + 32'd1;
            end
            cnt_d = cnt_q + (AW + 1)'(push) - (AW + 1)'(pop);

            case (state_q)
                ST_RUN:  if (halt_req)  state_d = ST_HALT;
                ST_HALT: if (!halt_req) state_d = ST_RUN;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            err_q   <= 1'b0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            err_q   <= err_d;
            fcnt_q  <= fcnt_d;
        end
    end

    // FIFO storage carries data only; validity is tracked by cnt_q.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wptr_q]    <= pc_q;
            instr_mem_q[wptr_q] <= imem_instr;
        end
    end

endmodule
